hazard_stall_unit: RTL and testbench

//  Producer-side counterpart of the EX-stage forwarding logic in the 5-stage RV32I pipeline.

---
 rtl/hazard_stall_unit.sv | 79 +++++++
 tb/tb_hazard_stall_unit.sv | 109 ++++++++++
 2 files changed

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: load-use/branch/memory-wait hazard detection driving pipeline enables, with perf counters
module hazard_stall_unit #(
  parameter int CNT_W    = 32,
  parameter int MAX_WAIT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             mem_memread,
  input  logic             mem_ready,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pipe_freeze,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  typedef enum logic {RUN, MEM_WAIT} state_t;
  state_t state, state_nx;
  logic [7:0] wait_cnt;
  logic lu, wt, stall_inc, flush_inc;
  assign lu = ex_memread && ex_rd != 5'd0 &&
              ((id_uses_rs1 && ex_rd == id_rs1) || (id_uses_rs2 && ex_rd == id_rs2));
  assign wt = mem_memread && !mem_ready;
  assign stall_inc = wt || (lu && !branch_taken);
  assign flush_inc = !wt && branch_taken;
  // outputs track wt directly; the state only qualifies the wait counter
  always_comb begin
    state_nx    = wt ? MEM_WAIT : RUN;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_freeze = 1'b0;
    if (!rst_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (wt) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      pipe_freeze = 1'b1;
    end else if (branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (lu) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= RUN;
      wait_cnt    <= 8'd0;
      mem_timeout <= 1'b0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= state == RUN ? 8'd0 : wait_cnt == 8'hff ? wait_cnt : wait_cnt + 8'd1;
      if (state == MEM_WAIT && wt && wait_cnt == 8'(MAX_WAIT - 1))
        mem_timeout <= 1'b1;
      if (stall_inc && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_inc && flush_cnt != '1)
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: directed vectors with a queue-based scoreboard checked at the falling edge
module tb_hazard_stall_unit;
  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_uses_rs1, id_uses_rs2, ex_memread, mem_memread, mem_ready, branch_taken;
  logic pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze, mem_timeout;
  logic [1:0] stall_cnt, flush_cnt;

  typedef struct {
    string    name;
    logic [4:0] outs;
    int       stall;
    int       flush;
    logic     to;
  } exp_t;
  exp_t sb[$];
  int passed = 0;
  int total = 0;
  bit done = 1'b0;

  hazard_stall_unit #(.CNT_W(2), .MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
    .ex_memread(ex_memread), .mem_memread(mem_memread), .mem_ready(mem_ready),
    .branch_taken(branch_taken), .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .pipe_freeze(pipe_freeze),
    .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d required %0d", name, act, req);
  endtask

  // outs = {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze}
  task automatic cyc(input string name, input logic rn, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic u1, input logic u2, input logic [4:0] rd, input logic exmr,
                     input logic memmr, input logic rdy, input logic br,
                     input logic [4:0] outs, input int st, input int fl, input logic to);
    exp_t e;
    rst_n = rn; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
    ex_rd = rd; ex_memread = exmr; mem_memread = memmr; mem_ready = rdy; branch_taken = br;
    e.name = name; e.outs = outs; e.stall = st; e.flush = fl; e.to = to;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.name, ".outs"}, int'({pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze}), int'(e.outs));
      chk({e.name, ".stall_cnt"}, int'(stall_cnt), e.stall);
      chk({e.name, ".flush_cnt"}, int'(flush_cnt), e.flush);
      chk({e.name, ".mem_timeout"}, int'(mem_timeout), int'(e.to));
    end
  end

  initial begin
    rst_n = 1'b0; id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_rd = '0; ex_memread = 0; mem_memread = 0; mem_ready = 0; branch_taken = 0;
    repeat (2) @(posedge clk);
    #1;
    //   name        rn rs1 rs2 u1 u2 rd exmr mmr rdy br  outs      st fl to
    cyc("reset0",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00110, 0, 0, 0);
    cyc("t1_lu",     1, 0, 5, 0, 1, 5, 1, 0, 0, 0, 5'b00010, 0, 0, 0);
    cyc("t1_after",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 1, 0, 0);
    cyc("t2_rd0",    1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 5'b11000, 1, 0, 0);
    cyc("t2_nouse",  1, 0, 5, 0, 0, 5, 1, 0, 0, 0, 5'b11000, 1, 0, 0);
    cyc("lu_rs1",    1, 7, 0, 1, 0, 7, 1, 0, 0, 0, 5'b00010, 1, 0, 0);
    cyc("lu_rs1_af", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 2, 0, 0);
    cyc("reset1",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00110, 2, 0, 0);
    cyc("t3_br_lu",  1, 0, 5, 0, 1, 5, 1, 0, 0, 1, 5'b11110, 0, 0, 0);
    cyc("t3_after",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 0, 1, 0);
    cyc("t4_w1",     1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 5'b00001, 0, 1, 0);
    cyc("t4_w2_lu",  1, 0, 5, 0, 1, 5, 1, 1, 0, 1, 5'b00001, 1, 1, 0);
    cyc("t4_w3",     1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 5'b00001, 2, 1, 0);
    cyc("t4_rel",    1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 5'b11110, 3, 1, 0);
    cyc("t4_after",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 3, 2, 0);
    cyc("reset2",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00110, 3, 2, 0);
    cyc("ld_ready",  1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 5'b11000, 0, 0, 0);
    cyc("t5_w1",     1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5'b00001, 0, 0, 0);
    cyc("t5_w2",     1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5'b00001, 1, 0, 0);
    cyc("t5_w3",     1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5'b00001, 2, 0, 0);
    cyc("t5_w4",     1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5'b00001, 3, 0, 0);
    cyc("t5_w5",     1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5'b00001, 3, 0, 0);
    cyc("t5_to",     1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5'b00001, 3, 0, 1);
    cyc("t5_idle1",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 3, 0, 1);
    cyc("t5_sticky", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 3, 0, 1);
    cyc("reset3",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00110, 3, 0, 1);
    cyc("t5_clear",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      cyc("t6_lu",   1, 0, 9, 0, 1, 9, 1, 0, 0, 0, 5'b00010, i > 3 ? 3 : i, 0, 0);
    cyc("t6_sat",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 3, 0, 0);
    cyc("rw_w1",     1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5'b00001, 3, 0, 0);
    cyc("rw_reset",  0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5'b00110, 3, 0, 0);
    cyc("rw_after",  1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 5'b11000, 0, 0, 0);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
